// File: rtl/demux_4_output_stream.sv
// demux_4_output_stream: 1-to-4 valid/ready stream demultiplexer with one registered slot per output.
//   Build option: define DEMUX_PKT_LOCK_EN to keep multi-beat packets on the output chosen by their first beat.
//   Ports:
//     clk, reset              rising-edge clock, synchronous active-high reset
//     in_data/in_sel/in_last  input beat, destination select (0..3), end-of-packet flag
//     in_valid/in_ready       input handshake; in_ready depends only on dest and y_ready
//     y0..y3                  registered slot data for outputs 0..3
//     y_last/y_valid          per-slot last flag and valid bit (bit i = output i)
//     y_ready                 per-output consumer ready
module demux_4_output_stream #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] y0,
    output logic [width-1:0] y1,
    output logic [width-1:0] y2,
    output logic [width-1:0] y3,
    output logic [3:0]       y_last,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready
);
    logic [3:0][width-1:0] data_q, data_d;
    logic [3:0]            last_q, last_d, valid_q, valid_d, hit;
    logic [1:0]            dest;
    logic                  acc;
`ifdef DEMUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state_q, state_d;
    logic [1:0] lock_q, lock_d;
    assign dest = state_q == LOCKED ? lock_q : in_sel;
    always_comb begin
        state_d = acc ? (in_last ? IDLE : LOCKED) : state_q;
        lock_d  = acc && state_q == IDLE && !in_last ? in_sel : lock_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end
`else
    assign dest = in_sel;
`endif
    // a full slot may be refilled in the same cycle it drains
    assign in_ready = !reset && (!valid_q[dest] || y_ready[dest]);
    assign acc      = in_valid && in_ready;
    assign hit      = acc ? 4'b0001 << dest : 4'b0000;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_d[i] = hit[i] ? in_data : data_q[i];
            last_d[i] = hit[i] ? in_last : last_q[i];
        end
        valid_d = hit | (valid_q & ~y_ready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            last_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
    assign y0      = data_q[0];
    assign y1      = data_q[1];
    assign y2      = data_q[2];
    assign y3      = data_q[3];
    assign y_last  = last_q;
    assign y_valid = valid_q;
endmodule

// File: tb/tb_demux_4_output_stream.sv
// tb_demux_4_output_stream: scoreboard bench for demux_4_output_stream (lock tests follow DEMUX_PKT_LOCK_EN).
module tb_demux_4_output_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  y_last, y_valid, y_ready;
    logic [31:0] yd [4];
    logic [32:0] sq [4][$];
    int          total = 0;
    int          bad = 0;

    demux_4_output_stream #(.width(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .y_last(y_last), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;
    assign yd[0] = y0;
    assign yd[1] = y1;
    assign yd[2] = y2;
    assign yd[3] = y3;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // every handshake on an output pops and compares the oldest expected beat for it
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (y_valid[i] && y_ready[i]) begin
                    if (sq[i].size() == 0) check($sformatf("extra_beat_y%0d", i), {y_last[i], yd[i]}, 64'hdead);
                    else check($sformatf("beat_y%0d", i), {y_last[i], yd[i]}, sq[i].pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] d, input logic l, input int o);
        int n = 0;
        in_sel = s;
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        else sq[o].push_back({l, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b1;
        in_sel = 2'd0;
        in_data = 32'h0;
        in_last = 1'b0;
        y_ready = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_y_valid", y_valid, 0);
            check("rst_y_last", y_last, 0);
            check("rst_y0", y0, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        idle(1);

        y_ready = 4'b1111;
        send(2'd2, 32'hA5A5_0001, 1'b1, 2);
        check("single_valid", y_valid, 4'b0100);
        check("single_y2", y2, 32'hA5A5_0001);
        check("single_last", y_last, 4'b0100);
        idle(1);
        check("single_clear", y_valid, 0);

`ifdef DEMUX_PKT_LOCK_EN
        send(2'd1, 32'h10, 1'b0, 1);
        send(2'd3, 32'h11, 1'b0, 1);
        send(2'd0, 32'h12, 1'b1, 1);
        send(2'd3, 32'h13, 1'b1, 3);
        send(2'd0, 32'hD0, 1'b0, 0);
        send(2'd1, 32'hD1, 1'b0, 0);
        send(2'd2, 32'hD2, 1'b1, 0);
`else
        send(2'd1, 32'h10, 1'b0, 1);
        send(2'd3, 32'h11, 1'b0, 3);
        send(2'd0, 32'h12, 1'b1, 0);
        send(2'd0, 32'hD0, 1'b0, 0);
        send(2'd1, 32'hD1, 1'b0, 1);
        send(2'd0, 32'hD2, 1'b1, 0);
`endif
        idle(3);
        check("stream_drained", y_valid, 0);

        y_ready = 4'b0000;
        send(2'd0, 32'hB0, 1'b1, 0);
        in_sel = 2'd0;
        in_data = 32'hB1;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("bp_hold_y0", y0, 32'hB0);
        check("bp_hold_valid", y_valid, 4'b0001);
        y_ready = 4'b0001;
        @(negedge clk);
        check("bp_in_ready_high", in_ready, 1);
        if (in_ready) sq[0].push_back({1'b1, 32'hB1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_refill_valid", y_valid, 4'b0001);
        check("bp_refill_y0", y0, 32'hB1);
        idle(2);

        y_ready = 4'b0000;
        send(2'd0, 32'hC0, 1'b1, 0);
        send(2'd3, 32'hC3, 1'b1, 3);
        check("par_valid", y_valid, 4'b1001);
        y_ready = 4'b1001;
        idle(1);
        check("par_drain", y_valid, 0);

        y_ready = 4'b0000;
        send(2'd2, 32'hE0, 1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sq[2].delete();
        check("mid_rst_valid", y_valid, 0);
        check("mid_rst_y2", y2, 0);
        y_ready = 4'b1111;
        send(2'd1, 32'hE1, 1'b1, 1);
        check("post_rst_route", y_valid, 4'b0010);
        idle(3);

        for (int i = 0; i < 4; i++) check($sformatf("q_empty_y%0d", i), sq[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_4_output_stream.md
Name: demux_4_output_stream

Overview:
- Parameterised 1-to-4 stream demultiplexer: routes one valid/ready input stream to one of four valid/ready output streams, selected by a 2-bit select.
- Sits at the fan-out end of datapaths whose fan-in side is built from 4-input multiplexers; it splits a shared bus back into four consumers.
- Each output has a one-entry register slot. A packet-lock FSM keeps multi-beat packets on one output.

Parameters:
- width, 32, data bits per beat on input and on each output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  width  input beat data
- in_sel  input  2  destination select, 0..3; sampled on the first beat of a packet
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the beat this cycle
- y0, y1, y2, y3  output  width each  output slot data, outputs 0..3
- y_last  output  4  bit i is the last flag of output slot i
- y_valid  output  4  bit i means output slot i holds a beat
- y_ready  input  4  bit i means consumer i takes the slot-i beat this cycle

Behaviour:
- Reset is synchronous and active-high, sampled on rising clk.
  - While reset is high: y_valid=0, y_last=0, y0..y3=0, FSM=IDLE, lock register=0, in_ready=0.
  - Reset mid-packet discards all held beats and any lock. The next accepted beat is treated as a packet start.
- Destination dest:
  - IDLE: dest = in_sel.
  - LOCKED: dest = lock register; in_sel is ignored.
- in_ready = !reset && (!y_valid[dest] || y_ready[dest]). It is combinational from dest and y_ready only and never depends on in_valid.
- Accept = in_valid && in_ready. On accept, slot[dest] loads in_data and in_last, and y_valid[dest] is 1 the next cycle. Input-to-output latency is exactly 1 cycle.
- Per slot i, each cycle:
  - accept into i: slot loads, valid=1.
  - else if y_valid[i] && y_ready[i]: valid=0, data and last hold.
  - else: hold.
- Accept into a full slot while it drains (simultaneous drain+fill) is allowed. This gives full throughput of 1 beat/cycle per output.
- Slots other than dest are unaffected by input traffic. They drain independently, so several y_valid bits can be high at once.
- Outputs are registered: y*, y_last and y_valid come directly from flops.
- FSM:
  - IDLE, accept with in_last=0: lock register=in_sel, go to LOCKED.
  - IDLE, accept with in_last=1: single-beat packet, stay IDLE.
  - LOCKED, accept with in_last=1: go to IDLE.
  - LOCKED, any other cycle: stay LOCKED.
- A stalled input (in_valid=1, in_ready=0) must hold in_data, in_sel and in_last stable. The block does not check this.
- No data width conversion; all data paths are exactly width bits.

Optional Feature:
- Macro: DEMUX_PKT_LOCK_EN.
- Defined: packet-lock FSM is present as described above.
- Not defined:
  - No FSM and no lock register.
  - dest = in_sel on every beat.
  - in_last is only carried through to y_last.
  - Ports are identical in both builds.

Test Plan:
- Reset and idle: hold reset=1 for 3 cycles with in_valid=1 -> in_ready=0 and y_valid=4'b0000 throughout; after release, in_ready=1.
- Single beat: in_sel=2, in_data=32'hA5A5_0001, in_last=1, y_ready=4'b1111 -> next cycle y_valid=4'b0100, y2=32'hA5A5_0001, y_last=4'b0100; then valid clears.
- Packet lock (DEMUX_PKT_LOCK_EN defined): 3 beats 32'h10, 32'h11, 32'h12 with in_sel=1,3,0 and in_last only on the third -> all three beats appear on y1; then a beat with in_sel=3 goes to y3.
- Backpressure:
  - y_ready[0]=0, send 2 beats to output 0 -> first beat held in y0, in_ready=0 on the second.
  - Raise y_ready[0] -> second beat accepted the same cycle the first drains, and y_valid[0] stays 1.
- Parallel drain: fill slots 0 and 3 on consecutive cycles with y_ready=0, then set y_ready=4'b1001 -> both valids drop in the same cycle, and data 32'hC0 and 32'hC3 are observed.
- Macro undefined plus reset mid-packet:
  - Multi-beat stream with in_sel=0,1 -> beats split to y0 and y1.
  - With macro defined, assert reset after beat 1 of a 3-beat packet to output 2 -> slots cleared, and the next beat routes by its own in_sel.
